// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encoding, owner encoding and default STARVE_MAX for mem_arbiter
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/prio_sel.sv
// prio_sel: data-over-fetch grant select with starvation override (in: en, if_req, dm_req, starve_cnt; out: if_gnt, dm_gnt)
module prio_sel
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CW = 3
) (
    input  logic          en,
    input  logic          if_req,
    input  logic          dm_req,
    input  logic [CW-1:0] starve_cnt,
    output logic          if_gnt,
    output logic          dm_gnt
);
    logic if_win;
    always_comb begin
        if_win = if_req && (!dm_req || starve_cnt == CW'(STARVE_MAX));
        if_gnt = en && if_win;
        dm_gnt = en && dm_req && !if_win;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one unified memory (in: clk, reset, if_*/dm_* requests, mem_ready/mem_rdata; out: grants, rvalid/rdata, mem_req/we/addr/wdata)
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    state_t        state, state_n;
    owner_t        owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] starve_cnt;
    // grants are gated by reset so every output is 0 while reset is held
    prio_sel #(.STARVE_MAX(STARVE_MAX), .CW(CW)) u_prio (
        .en(state == IDLE && reset),
        .if_req(if_req),
        .dm_req(dm_req),
        .starve_cnt(starve_cnt),
        .if_gnt(if_gnt),
        .dm_gnt(dm_gnt)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = IDLE;
        if (state == IDLE) state_n = (if_gnt || dm_gnt) ? BUSY : IDLE;
        if (state == BUSY) state_n = mem_ready ? RESP : BUSY;
        mem_req = state == BUSY;
        mem_we = mem_req && we_q;
        mem_addr = {addr_q[AW-1:2], 2'b00};
        mem_wdata = wdata_q;
        if_rvalid = state == RESP && owner == OWN_IF;
        dm_rvalid = state == RESP && owner == OWN_DM;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= OWN_IF;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            starve_cnt <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if (if_gnt || dm_gnt) begin
                owner <= dm_gnt ? OWN_DM : OWN_IF;
                we_q <= dm_gnt && dm_we;
                addr_q <= dm_gnt ? dm_addr : if_addr;
                wdata_q <= dm_wdata;
            end
            if (if_gnt) starve_cnt <= '0;
            else if (dm_gnt && if_req) starve_cnt <= starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
            else if (state == IDLE && !if_req) starve_cnt <= '0;
            if (state == BUSY && mem_ready && owner == OWN_IF) if_rdata <= mem_rdata;
            // stores complete without touching the load data register
            if (state == BUSY && mem_ready && owner == OWN_DM && !we_q) dm_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (vector table, corner sequences, randomized traffic vs transaction model)
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int SM = 4;

    logic clk = 0, reset = 0;
    logic if_req = 0, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr = 0;
    logic [31:0] if_rdata;
    logic dm_req = 0, dm_we = 0, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr = 0;
    logic [31:0] dm_wdata = 0, dm_rdata;
    logic mem_req, mem_we, mem_ready = 0;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit fetch;
        bit we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int lat;
        logic [31:0] maddr;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[8];

    // memory model (word-indexed) and stimulus controls
    logic [31:0] mem [logic [29:0]];
    int lat = 0, wait_n = 0;
    bit stray = 0, rnd = 0, keep = 0;
    bit new_if = 0, new_dm = 0, ndm_we = 0;
    logic [31:0] nif_addr = 0, ndm_addr = 0, ndm_wdata = 0;
    bit g_if = 0, g_dm = 0;

    // transaction-level reference: 0 free, 1 memory access, 2 response
    int phase = 0, cnt = 0;
    bit own_dm = 0, sb_we = 0;
    logic [31:0] sb_addr = 0, sb_wdata = 0, exp_if = 0, exp_dm = 0;

    // grant log: 1 = data, 0 = fetch, newest in bit 0
    logic [7:0] ord = 0;
    int ord_n = 0, tcnt = 0, t_first = 0, t_last = 0;

    function automatic logic [31:0] rd(logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit wi, wd;
        int ph;
        @(negedge clk);
        if (g_if && !keep) if_req = 0;
        if (g_dm && !keep) dm_req = 0;
        if (new_if) begin if_req = 1; if_addr = nif_addr; new_if = 0; end
        if (new_dm) begin dm_req = 1; dm_we = ndm_we; dm_addr = ndm_addr; dm_wdata = ndm_wdata; new_dm = 0; end
        if (rnd) begin
            if (!if_req && $urandom_range(3) == 0) begin if_req = 1; if_addr = $urandom_range(255); end
            if (!dm_req && $urandom_range(2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(1)); dm_addr = $urandom_range(255); dm_wdata = $urandom;
            end
        end
        if (mem_req) begin
            mem_ready = wait_n >= lat;
            mem_rdata = rd(mem_addr);
            wait_n++;
            if (mem_ready) begin
                if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
                wait_n = 0;
                if (rnd) lat = $urandom_range(2);
            end
        end else begin
            mem_ready = stray && $urandom_range(1) == 1;
            mem_rdata = $urandom;
        end
        #1;
        wi = phase == 0 && if_req && (!dm_req || cnt == SM);
        wd = phase == 0 && dm_req && !wi;
        chk("if_gnt", if_gnt, wi);
        chk("dm_gnt", dm_gnt, wd);
        chk("mem_req", mem_req, phase == 1);
        chk("mem_we", mem_we, phase == 1 && sb_we);
        chk("if_rvalid", if_rvalid, phase == 2 && !own_dm);
        chk("dm_rvalid", dm_rvalid, phase == 2 && own_dm);
        chk("if_rdata", if_rdata, exp_if);
        chk("dm_rdata", dm_rdata, exp_dm);
        if (phase == 1) begin
            chk("mem_addr", mem_addr, sb_addr & ~32'h3);
            if (sb_we) chk("mem_wdata", mem_wdata, sb_wdata);
        end
        if (if_gnt || dm_gnt) begin
            ord = {ord[6:0], dm_gnt};
            ord_n++;
            if (ord_n == 1) t_first = tcnt;
            t_last = tcnt;
        end
        g_if = if_gnt;
        g_dm = dm_gnt;
        ph = phase;
        if (ph == 0) cnt = wi ? 0 : (wd && if_req) ? (cnt == SM ? SM : cnt + 1) : !if_req ? 0 : cnt;
        if (ph == 0 && (wi || wd)) begin
            phase = 1; own_dm = wd; sb_we = wd && dm_we;
            sb_addr = wd ? dm_addr : if_addr; sb_wdata = dm_wdata;
        end else if (ph == 1 && mem_ready) begin
            phase = 2;
            if (!own_dm) exp_if = rd(sb_addr);
            else if (!sb_we) exp_dm = rd(sb_addr);
        end else if (ph == 2) phase = 0;
        tcnt++;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] seen_addr;
        bit seen_we;
        int n;
        seen_addr = '1; seen_we = 0; n = 0;
        lat = v.lat;
        if (v.fetch) begin new_if = 1; nif_addr = v.addr; end
        else begin new_dm = 1; ndm_we = v.we; ndm_addr = v.addr; ndm_wdata = v.wdata; end
        do begin
            tick(); n++;
            if (mem_req) begin seen_addr = mem_addr; seen_we |= mem_we; end
        end while (!(if_rvalid || dm_rvalid) && n < 30);
        chk("vec rvalid", v.fetch ? if_rvalid : dm_rvalid, 1);
        chk("vec mem_addr", seen_addr, v.maddr);
        chk("vec mem_we", seen_we, v.we && !v.fetch);
        chk("vec rdata", v.fetch ? if_rdata : dm_rdata, v.rdata);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((if_req || dm_req || phase != 0) && n < 60) begin tick(); n++; end
        chk("drain timeout", if_req || dm_req || phase != 0, 0);
    endtask

    initial begin
        vec_t av;
        int n;
        mem[30'h1] = 32'h1234_5678;
        vecs[0] = '{1'b1, 1'b0, 32'h6,         32'h0,         2, 32'h4,         32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 32'h8,         32'd100,       0, 32'h8,         32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h8,         32'h0,         1, 32'h8,         32'd100};
        vecs[3] = '{1'b0, 1'b0, 32'hB,         32'h0,         0, 32'h8,         32'd100};
        vecs[4] = '{1'b1, 1'b0, 32'hB,         32'h0,         0, 32'h8,         32'd100};
        vecs[5] = '{1'b0, 1'b1, 32'h13,        32'hDEAD_BEEF, 3, 32'h10,        32'd100};
        vecs[6] = '{1'b0, 1'b0, 32'h10,        32'h0,         0, 32'h10,        32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 1'b0, 32'h1000_0003, 32'h0,         1, 32'h1000_0000, 32'h0};
        av      = '{1'b0, 1'b0, 32'h8,         32'h0,         0, 32'h8,         32'd100};

        repeat (2) tick();
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        reset = 1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // simultaneous requests with an empty starvation count: data first, fetch three cycles later
        lat = 0; ord = 0; ord_n = 0;
        new_if = 1; nif_addr = 32'h40; new_dm = 1; ndm_we = 0; ndm_addr = 32'h8;
        n = 0;
        while (ord_n < 2 && n < 30) begin tick(); n++; end
        chk("tie order", ord[1:0], 2'b10);
        chk("tie spacing", t_last - t_first, 3);
        drain();

        // both requesters always asking: four data grants, then fetch breaks through
        keep = 1; ord = 0; ord_n = 0;
        new_if = 1; nif_addr = 32'h44; new_dm = 1; ndm_we = 0; ndm_addr = 32'hC;
        n = 0;
        while (ord_n < 6 && n < 60) begin tick(); n++; end
        chk("starve order", ord[5:0], 6'b111101);
        keep = 0;
        drain();

        // stray mem_ready while idle must be ignored
        stray = 1;
        repeat (6) tick();
        stray = 0;
        run_vec(vecs[2]);

        // reset in the middle of a memory access
        lat = 5; new_if = 1; nif_addr = 32'h24;
        n = 0;
        do begin tick(); n++; end while (!mem_req && n < 10);
        chk("abort busy", mem_req, 1);
        #1 reset = 0;
        #1;
        chk("abort mem_req", mem_req, 0);
        chk("abort if_rvalid", if_rvalid, 0);
        chk("abort mem_addr", mem_addr, 0);
        phase = 0; cnt = 0; exp_if = 0; exp_dm = 0;
        if_req = 0; dm_req = 0; g_if = 0; g_dm = 0; wait_n = 0; mem_ready = 0;
        repeat (3) tick();
        reset = 1;
        run_vec(av);

        // randomized traffic with random latency and stray ready pulses
        rnd = 1; stray = 1;
        repeat (1500) tick();
        rnd = 0; stray = 0; lat = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
